// File: rtl/cpu_pkg.sv
// Shared types for the CPU sequencer: state encodings, opcode constants and
// the control-word layout driven onto the datapath.
package cpu_pkg;

  typedef enum logic [2:0] {
    FETCH1 = 3'd0,
    FETCH2 = 3'd1,
    EXEC1  = 3'd2,
    EXEC2  = 3'd3,
    HALT   = 3'd4
  } state_e;

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_LDA   = 4'h1;
  localparam logic [3:0] OP_LDB   = 4'h2;
  localparam logic [3:0] OP_MOVAC = 4'h3;
  localparam logic [3:0] OP_MOVBD = 4'h4;
  localparam logic [3:0] OP_ADD   = 4'h5;
  localparam logic [3:0] OP_OUT   = 4'h6;
  localparam logic [3:0] OP_JMP   = 4'h7;
  localparam logic [3:0] OP_JEQ   = 4'h8;
  localparam logic [3:0] OP_JOV   = 4'h9;
  localparam logic [3:0] OP_LDI   = 4'hA;
  localparam logic [3:0] OP_HLT   = 4'hF;

  typedef struct packed {
    logic lp;
    logic ep;
    logic c;
    logic la;
    logic ea;
    logic lb;
    logic eb;
    logic lc;
    logic ld;
    logic es;
    logic lm;
    logic em;
    logic li;
    logic ei;
    logic lo;
  } ctrl_t;

  function automatic logic is_mem_load(input logic [3:0] op);
    return (op == OP_LDA) || (op == OP_LDB);
  endfunction

endpackage

// File: rtl/cpu_sequencer_if.sv
// Sequencer-to-datapath bundle: run/opcode/flag inputs and the control lines.
interface cpu_sequencer_if;
  logic       run;
  logic [3:0] ir_op;
  logic       c_eq_d;
  logic       s_ov;
  logic       lp, ep, c;
  logic       la, ea, lb, eb, lc, ld;
  logic       es, lm, em, li, ei, lo;
  logic       halted;
  logic [2:0] state;

  // Sequencer side
  modport master (
    input  run, ir_op, c_eq_d, s_ov,
    output lp, ep, c, la, ea, lb, eb, lc, ld,
    output es, lm, em, li, ei, lo, halted, state
  );

  // Datapath side
  modport slave (
    output run, ir_op, c_eq_d, s_ov,
    input  lp, ep, c, la, ea, lb, eb, lc, ld,
    input  es, lm, em, li, ei, lo, halted, state
  );
endinterface

// File: rtl/cpu_ctrl_decode.sv
// Combinational control-word decode from current state, run, opcode and flags.
module cpu_ctrl_decode
  import cpu_pkg::*;
(
  input  state_e     state_i,
  input  logic       run_i,
  input  logic [3:0] ir_op_i,
  input  logic       c_eq_d_i,
  input  logic       s_ov_i,
  output ctrl_t      ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    case (state_i)
      FETCH1: begin
        if (run_i) begin
          ctrl_o.ep = 1'b1;
          ctrl_o.lm = 1'b1;
        end
      end
      FETCH2: begin
        ctrl_o.em = 1'b1;
        ctrl_o.li = 1'b1;
        ctrl_o.c  = 1'b1;
      end
      EXEC1: begin
        case (ir_op_i)
          OP_LDA, OP_LDB: begin
            ctrl_o.ei = 1'b1;
            ctrl_o.lm = 1'b1;
          end
          OP_MOVAC: begin
            ctrl_o.ea = 1'b1;
            ctrl_o.lc = 1'b1;
          end
          OP_MOVBD: begin
            ctrl_o.eb = 1'b1;
            ctrl_o.ld = 1'b1;
          end
          OP_ADD: begin
            ctrl_o.es = 1'b1;
            ctrl_o.la = 1'b1;
          end
          OP_OUT: begin
            ctrl_o.ea = 1'b1;
            ctrl_o.lo = 1'b1;
          end
          OP_JMP: begin
            ctrl_o.ei = 1'b1;
            ctrl_o.lp = 1'b1;
          end
          OP_JEQ: begin
            ctrl_o.ei = c_eq_d_i;
            ctrl_o.lp = c_eq_d_i;
          end
          OP_JOV: begin
            ctrl_o.ei = s_ov_i;
            ctrl_o.lp = s_ov_i;
          end
          OP_LDI: begin
            ctrl_o.ei = 1'b1;
            ctrl_o.la = 1'b1;
          end
          default: ;
        endcase
      end
      EXEC2: begin
        // Second memory cycle of a load: memory drives the bus into A or B
        ctrl_o.em = is_mem_load(ir_op_i);
        ctrl_o.la = (ir_op_i == OP_LDA);
        ctrl_o.lb = (ir_op_i == OP_LDB);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/cpu_sequencer.sv
// Instruction sequencer: state register, next-state logic and gated controls.
module cpu_sequencer
  import cpu_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  cpu_sequencer_if.master bus
);

  state_e state_q, state_d;
  ctrl_t  dec_ctrl;
  ctrl_t  ctrl;

  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH1: state_d = bus.run ? FETCH2 : FETCH1;
      FETCH2: state_d = EXEC1;
      EXEC1: begin
        if (is_mem_load(bus.ir_op))  state_d = EXEC2;
        else if (bus.ir_op == OP_HLT) state_d = HALT;
        else                          state_d = FETCH1;
      end
      EXEC2:   state_d = FETCH1;
      HALT:    state_d = HALT;
      default: state_d = FETCH1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= FETCH1;
    else     state_q <= state_d;
  end

  cpu_ctrl_decode u_decode (
    .state_i  (state_q),
    .run_i    (bus.run),
    .ir_op_i  (bus.ir_op),
    .c_eq_d_i (bus.c_eq_d),
    .s_ov_i   (bus.s_ov),
    .ctrl_o   (dec_ctrl)
  );

  // Gate with rst so outputs drop in the same instant reset is applied
  assign ctrl = rst ? '0 : dec_ctrl;

  assign bus.lp     = ctrl.lp;
  assign bus.ep     = ctrl.ep;
  assign bus.c      = ctrl.c;
  assign bus.la     = ctrl.la;
  assign bus.ea     = ctrl.ea;
  assign bus.lb     = ctrl.lb;
  assign bus.eb     = ctrl.eb;
  assign bus.lc     = ctrl.lc;
  assign bus.ld     = ctrl.ld;
  assign bus.es     = ctrl.es;
  assign bus.lm     = ctrl.lm;
  assign bus.em     = ctrl.em;
  assign bus.li     = ctrl.li;
  assign bus.ei     = ctrl.ei;
  assign bus.lo     = ctrl.lo;
  assign bus.halted = (state_q == HALT) && !rst;
  assign bus.state  = state_q;

endmodule

// File: doc/cpu_sequencer.md
CPU_SEQUENCER -- requirements
Module: cpu_sequencer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, with ports ordered as listed below.
REQ-002 clk  input  1  system clock; all state changes occur on the rising edge.
REQ-003 rst  input  1  asynchronous active-high reset.
REQ-004 run  input  1  when low, the sequencer holds in FETCH1 with all controls low.
REQ-005 ir_op  input  4  instruction register high nibble, valid from EXEC1 onward.
REQ-006 c_eq_d, s_ov  input  1 each  ALU flags, sampled combinationally in EXEC1.
REQ-007 lp, ep, c  output  1 each  PC load, PC bus enable, PC increment.
REQ-008 la, ea, lb, eb, lc, ld  output  1 each  register load and enable lines.
REQ-009 es, lm, em, li, ei, lo  output  1 each  ALU enable, MAR load, memory enable, IR load, IR operand enable, output-register load.
REQ-010 halted  output  1  high while in state HALT.
REQ-011 state  output  3  current state encoding, for debug.

Function
REQ-012 The sequencer SHALL implement the states FETCH1, FETCH2, EXEC1, EXEC2 and HALT.
REQ-013 All control outputs SHALL be combinational from state, ir_op and flags, and SHALL be forced low while rst is high.
REQ-014 FETCH1 (run=1): assert ep, lm; next state FETCH2.
REQ-015 FETCH1 (run=0): assert no controls; remain in FETCH1.
REQ-016 FETCH2: assert em, li, c; next state EXEC1.
REQ-017 Opcode decode in EXEC1 SHALL be as follows:
- 0x1 LDA: ei, lm; go to EXEC2.
- 0x2 LDB: ei, lm; go to EXEC2.
- 0x3 MOVAC: ea, lc.
- 0x4 MOVBD: eb, ld.
- 0x5 ADD: es, la.
- 0x6 OUT: ea, lo.
- 0x7 JMP: ei, lp.
- 0x8 JEQ: ei, lp only if c_eq_d=1.
- 0x9 JOV: ei, lp only if s_ov=1.
- 0xA LDI: ei, la.
- 0xF HLT: no controls; go to HALT.
- 0x0 and 0xB-0xE: NOP, no controls.
REQ-018 Every EXEC1 case not listed with an explicit next state SHALL return to FETCH1.
REQ-019 EXEC2 SHALL assert em with la (LDA) or em with lb (LDB), then return to FETCH1.
REQ-020 Instruction length SHALL be 3 cycles (single-step) or 4 cycles (LDA/LDB).
REQ-021 HALT SHALL assert no controls, ignore run, and persist until rst.
REQ-022 At most one of ep, ea, eb, es, em, ei SHALL be high in any cycle.
REQ-023 run falling mid-instruction SHALL have no effect until the next FETCH1.
REQ-024 A flag change outside EXEC1 SHALL have no effect.

Reset
REQ-025 Asserting rst SHALL force state=FETCH1, halted=0 and all control outputs 0 immediately, regardless of the clock.
REQ-026 After rst deasserts with run=1, the first rising edge SHALL advance FETCH1 to FETCH2.
REQ-027 Reset asserted in any state, including HALT or EXEC2, SHALL abort the current instruction without completing it.

Structure
REQ-028 The opcode constants and state encodings SHALL reside in the shared package cpu_pkg.
REQ-029 Per-state control decode SHALL be a combinational sub-module, cpu_ctrl_decode.
REQ-030 The state register and next-state logic SHALL reside in cpu_sequencer.

Verification
REQ-031 Reset, then run=1 with ir_op=0x1 -> cycles show {ep,lm}, {em,li,c}, {ei,lm}, {em,la}, then FETCH1.
REQ-032 ir_op=0x8 with c_eq_d=1 -> EXEC1 shows {ei,lp}; with c_eq_d=0 -> EXEC1 shows no controls; both return to FETCH1.
REQ-033 ir_op=0xF -> halted=1 from the cycle after EXEC1; 20 further cycles with run toggling show all controls 0.
REQ-034 rst pulsed asynchronously during EXEC2 of LDB -> lb never asserts; state=FETCH1 immediately.
REQ-035 run=0 after reset for 5 cycles -> state=FETCH1 and no controls; run=1 -> fetch begins on the next edge.
REQ-036 A random opcode stream of 1000 instructions -> bus-enable one-hot invariant holds (at most one enable high) in every cycle.
